// File: rtl/thread_scheduler_if.sv
// Scheduler bundle: thread enable/stall/block/wake inputs and PC-array drive outputs.
// The scheduler sits on the slave modport; whoever feeds it uses master.
interface thread_scheduler_if #(
  parameter int THREAD_INDEX_BITS = 3
);
  localparam int N = 1 << THREAD_INDEX_BITS;

  logic [N-1:0]                 in_thread_enable;
  logic                         in_stall;
  logic                         in_block_valid;
  logic [THREAD_INDEX_BITS-1:0] in_block_thread_index;
  logic                         in_wake_valid;
  logic [THREAD_INDEX_BITS-1:0] in_wake_thread_index;
  logic [THREAD_INDEX_BITS-1:0] out_thread_index;
  logic                         out_issue_valid;
  logic                         out_idle;

  modport master (
    output in_thread_enable, in_stall,
    output in_block_valid, in_block_thread_index,
    output in_wake_valid, in_wake_thread_index,
    input  out_thread_index, out_issue_valid, out_idle
  );

  modport slave (
    input  in_thread_enable, in_stall,
    input  in_block_valid, in_block_thread_index,
    input  in_wake_valid, in_wake_thread_index,
    output out_thread_index, out_issue_valid, out_idle
  );
endinterface

// File: rtl/thread_scheduler.sv
// Round-robin issue scheduler for the multithreaded fetch stage.
// Define THREAD_SCHED_COOLDOWN_EN to add the per-thread reissue cooldown counters.
module thread_scheduler #(
  parameter int THREAD_INDEX_BITS = 3,
  parameter int REISSUE_GAP       = 5
) (
  input logic               clk,
  input logic               reset,
  thread_scheduler_if.slave bus
);
  localparam int N = 1 << THREAD_INDEX_BITS;
  localparam logic [THREAD_INDEX_BITS-1:0] LAST_AT_RESET = THREAD_INDEX_BITS'(N - 1);

  logic                         issue_r;
  logic [THREAD_INDEX_BITS-1:0] index_r;
  logic [THREAD_INDEX_BITS-1:0] last_r;
  logic                         idle_r;
  logic [N-1:0]                 blocked_r;

  logic [N-1:0]                 cooled_s;
  logic [N-1:0]                 eligible_s;
  logic                         load_s;
  logic                         hit_s;
  logic [THREAD_INDEX_BITS-1:0] hit_index_s;

`ifdef THREAD_SCHED_COOLDOWN_EN
  localparam logic [3:0] COOLDOWN_LOAD = 4'(REISSUE_GAP - 1);
  logic [3:0] cooldown_r [N];

  // A thread is cool once its reissue counter has drained to zero.
  always_comb begin
    cooled_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      cooled_s[i] = (cooldown_r[i] == 4'd0);
    end
  end

  // Reload on issue; otherwise drain only on edges where the pipe advances.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        cooldown_r[i] <= 4'd0;
      end else if (load_s && hit_s && (hit_index_s == THREAD_INDEX_BITS'(i))) begin
        cooldown_r[i] <= COOLDOWN_LOAD;
      end else if (!bus.in_stall && (cooldown_r[i] != 4'd0)) begin
        cooldown_r[i] <= cooldown_r[i] - 4'd1;
      end else begin
        cooldown_r[i] <= cooldown_r[i];
      end
    end
  end
`else
  assign cooled_s = {N{1'b1}};
`endif

  assign eligible_s = bus.in_thread_enable & ~blocked_r & cooled_s;
  // A pending issue that is stalled keeps its slot; anything else reselects.
  assign load_s     = ~(issue_r & bus.in_stall);

  // Scan starts one past the last issued thread so every runnable thread gets a turn.
  always_comb begin
    logic [THREAD_INDEX_BITS-1:0] cand_v;
    cand_v      = last_r;
    hit_s       = 1'b0;
    hit_index_s = {THREAD_INDEX_BITS{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand_v      = last_r + THREAD_INDEX_BITS'(k);
      hit_index_s = (!hit_s && eligible_s[cand_v]) ? cand_v : hit_index_s;
      hit_s       = hit_s | eligible_s[cand_v];
    end
  end

  // Selection state; an empty scan keeps index/last so the pointer does not drift.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_r <= 1'b0;
      index_r <= {THREAD_INDEX_BITS{1'b0}};
      last_r  <= LAST_AT_RESET;
      idle_r  <= 1'b1;
    end else if (load_s && hit_s) begin
      issue_r <= 1'b1;
      index_r <= hit_index_s;
      last_r  <= hit_index_s;
      idle_r  <= 1'b0;
    end else if (load_s) begin
      issue_r <= 1'b0;
      index_r <= index_r;
      last_r  <= last_r;
      idle_r  <= 1'b1;
    end else begin
      issue_r <= issue_r;
      index_r <= index_r;
      last_r  <= last_r;
      idle_r  <= idle_r;
    end
  end

  // Block/wake bookkeeping; block is checked first so it wins a same-index collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        blocked_r[i] <= 1'b0;
      end else if (bus.in_block_valid && (bus.in_block_thread_index == THREAD_INDEX_BITS'(i))) begin
        blocked_r[i] <= 1'b1;
      end else if (bus.in_wake_valid && (bus.in_wake_thread_index == THREAD_INDEX_BITS'(i))) begin
        blocked_r[i] <= 1'b0;
      end else begin
        blocked_r[i] <= blocked_r[i];
      end
    end
  end

  assign bus.out_thread_index = index_r;
  assign bus.out_issue_valid  = issue_r & ~bus.in_stall;
  assign bus.out_idle         = idle_r;
endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios plus a randomized
// run against a reference model, all through an expected-value queue.
module tb_thread_scheduler;
  localparam int TIB = 3;
  localparam int N   = 8;
  localparam int GAP = 5;
`ifdef THREAD_SCHED_COOLDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  thread_scheduler_if #(.THREAD_INDEX_BITS(TIB)) bus ();

  thread_scheduler #(.THREAD_INDEX_BITS(TIB), .REISSUE_GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           valid;
    logic [TIB-1:0] index;
    logic           idle;
  } obs_t;

  obs_t sb[$];
  obs_t exp_v;
  obs_t got_v;
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic obs_t mk(input logic v, input int idx, input logic idle);
    obs_t o;
    o.valid = v;
    o.index = idx[TIB-1:0];
    o.idle  = idle;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("valid=%0b index=%0d idle=%0b", o.valid, o.index, o.idle);
  endfunction

  task automatic quiet(input logic [N-1:0] en);
    bus.in_thread_enable      = en;
    bus.in_stall              = 1'b0;
    bus.in_block_valid        = 1'b0;
    bus.in_block_thread_index = 3'd0;
    bus.in_wake_valid         = 1'b0;
    bus.in_wake_thread_index  = 3'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle with reset low (outputs still show reset state).
  task automatic do_reset(input logic [N-1:0] en);
    quiet(en);
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    quiet(8'hFF);
    bus.in_stall       = 1'b1;
    bus.in_block_valid = 1'b1;
    bus.in_wake_valid  = 1'b1;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      sb.push_back(mk(1'b0, 0, 1'b1));
      @(negedge clk);
      got_v = {bus.out_issue_valid, bus.out_thread_index, bus.out_idle};
      exp_v = sb.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset c%0d: got %s, expected %s", c, fmt(got_v), fmt(exp_v));
      end
      bus.in_stall = 1'b0;
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    do_reset(8'hFF);
    for (int c = 0; c <= 9; c++) begin
      if (c == 0) sb.push_back(mk(1'b0, 0, 1'b1));
      else        sb.push_back(mk(1'b1, (c - 1) % 8, 1'b0));
      @(negedge clk);
      got_v = {bus.out_issue_valid, bus.out_thread_index, bus.out_idle};
      exp_v = sb.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL round_robin c%0d: got %s, expected %s", c, fmt(got_v), fmt(exp_v));
      end
      next_cycle();
    end
  endtask

  // Sparse (two threads) and single-thread enables; -1 marks an empty slot.
  task automatic test_sparse(input logic [N-1:0] en, input int held_idx);
    int seq [10];
`ifdef THREAD_SCHED_COOLDOWN_EN
    if (en == 8'h05) seq = '{0, 2, -1, -1, -1, 0, 2, -1, -1, -1};
    else             seq = '{3, -1, -1, -1, -1, 3, -1, -1, -1, -1};
`else
    if (en == 8'h05) seq = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 2};
    else             seq = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
`endif
    do_reset(en);
    for (int c = 0; c <= 10; c++) begin
      if (c == 0)               sb.push_back(mk(1'b0, 0, 1'b1));
      else if (seq[c-1] < 0)    sb.push_back(mk(1'b0, held_idx, 1'b1));
      else                      sb.push_back(mk(1'b1, seq[c-1], 1'b0));
      @(negedge clk);
      got_v = {bus.out_issue_valid, bus.out_thread_index, bus.out_idle};
      exp_v = sb.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL sparse_en%02h c%0d: got %s, expected %s", en, c, fmt(got_v), fmt(exp_v));
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    do_reset(8'hFF);
    for (int c = 0; c <= 12; c++) begin
      bus.in_stall = (c >= 4 && c <= 6);
      if (c == 0)      sb.push_back(mk(1'b0, 0, 1'b1));
      else if (c <= 3) sb.push_back(mk(1'b1, c - 1, 1'b0));
      else if (c <= 6) sb.push_back(mk(1'b0, 3, 1'b0));
      else if (c == 7) sb.push_back(mk(1'b1, 3, 1'b0));
      else             sb.push_back(mk(1'b1, (c - 4) % 8, 1'b0));
      @(negedge clk);
      got_v = {bus.out_issue_valid, bus.out_thread_index, bus.out_idle};
      exp_v = sb.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL stall c%0d: got %s, expected %s", c, fmt(got_v), fmt(exp_v));
      end
      next_cycle();
    end
  endtask

  task automatic test_block_wake();
    int seq [15] = '{0, 1, 3, 4, 6, 7, 0, 1, 3, 4, 6, 0, 1, 2, 3};
    do_reset(8'hFF);
    for (int c = 0; c <= 15; c++) begin
      quiet(8'hFF);
      if (c == 0) begin
        bus.in_block_valid = 1'b1; bus.in_block_thread_index = 3'd2;
      end else if (c == 1) begin
        bus.in_block_valid = 1'b1; bus.in_block_thread_index = 3'd5;
        bus.in_wake_valid  = 1'b1; bus.in_wake_thread_index  = 3'd5;
      end else if (c == 9) begin
        bus.in_block_valid = 1'b1; bus.in_block_thread_index = 3'd7;
        bus.in_wake_valid  = 1'b1; bus.in_wake_thread_index  = 3'd2;
      end
      if (c == 0) sb.push_back(mk(1'b0, 0, 1'b1));
      else        sb.push_back(mk(1'b1, seq[c-1], 1'b0));
      @(negedge clk);
      got_v = {bus.out_issue_valid, bus.out_thread_index, bus.out_idle};
      exp_v = sb.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL block_wake c%0d: got %s, expected %s", c, fmt(got_v), fmt(exp_v));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midstream();
    int seq [12] = '{-2, 0, 2, 3, 5, 6, -2, 0, 1, 2, 3, 4};
    do_reset(8'hFF);
    for (int c = 0; c <= 11; c++) begin
      quiet(8'hFF);
      reset = (c == 5);
      if (c == 0) begin
        bus.in_block_valid = 1'b1; bus.in_block_thread_index = 3'd1;
      end else if (c == 1) begin
        bus.in_block_valid = 1'b1; bus.in_block_thread_index = 3'd4;
      end else if (c == 5) begin
        bus.in_stall       = 1'b1;
        bus.in_block_valid = 1'b1; bus.in_block_thread_index = 3'd0;
        bus.in_wake_valid  = 1'b1; bus.in_wake_thread_index  = 3'd1;
      end
      if (seq[c] == -2) sb.push_back(mk(1'b0, 0, 1'b1));
      else if (c == 5)  sb.push_back(mk(1'b0, 6, 1'b0));
      else              sb.push_back(mk(1'b1, seq[c], 1'b0));
      @(negedge clk);
      got_v = {bus.out_issue_valid, bus.out_thread_index, bus.out_idle};
      exp_v = sb.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_midstream c%0d: got %s, expected %s", c, fmt(got_v), fmt(exp_v));
      end
      next_cycle();
    end
    reset = 1'b0;
  endtask

  // Random enables, stalls, blocks and wakes checked against a cycle model.
  task automatic test_random();
    logic           m_issue = 1'b0;
    int             m_idx   = 0;
    int             m_last  = N - 1;
    logic           m_idle  = 1'b1;
    logic [N-1:0]   m_blk   = '0;
    int             m_cd [N];
    logic [N-1:0]   en;
    logic           st, bv, wv;
    int             bi, wi, pick, j;
    bit             found, load;
    for (int i = 0; i < N; i++) m_cd[i] = 0;
    do_reset(8'h00);
    for (int c = 0; c < 300; c++) begin
      en = 8'($urandom);
      st = ($urandom_range(0, 3) == 0);
      bv = ($urandom_range(0, 3) == 0);
      wv = ($urandom_range(0, 2) == 0);
      bi = $urandom_range(0, N - 1);
      wi = $urandom_range(0, N - 1);
      bus.in_thread_enable      = en;
      bus.in_stall              = st;
      bus.in_block_valid        = bv;
      bus.in_block_thread_index = bi[TIB-1:0];
      bus.in_wake_valid         = wv;
      bus.in_wake_thread_index  = wi[TIB-1:0];
      sb.push_back(mk(m_issue & ~st, m_idx, m_idle));
      @(negedge clk);
      got_v = {bus.out_issue_valid, bus.out_thread_index, bus.out_idle};
      exp_v = sb.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL random c%0d: got %s, expected %s (en=%02h stall=%0b)", c, fmt(got_v), fmt(exp_v), en, st);
      end
      load  = !(m_issue && st);
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && en[j] && !m_blk[j] && (!CD_EN || m_cd[j] == 0)) begin
          found = 1'b1;
          pick  = j;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (load && found && i == pick) m_cd[i] = GAP - 1;
        else if (!st && m_cd[i] > 0)    m_cd[i] = m_cd[i] - 1;
      end
      if (load) begin
        m_issue = found;
        m_idle  = !found;
        if (found) begin
          m_idx  = pick;
          m_last = pick;
        end
      end
      if (wv) m_blk[wi] = 1'b0;
      if (bv) m_blk[bi] = 1'b1;
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    quiet(8'h00);
    test_reset();
    test_round_robin();
    test_sparse(8'h05, 2);
    test_sparse(8'h08, 3);
    test_stall();
    test_block_wake();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
    $fatal(1);
  end
endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Round-robin issue scheduler for the multithreaded fetch stage. Each cycle it selects one runnable hardware thread and drives the per-thread PC array's thread index and increment flag. It tracks per-thread enable, block/wake events from downstream stages and an optional per-thread reissue cooldown for hazard avoidance. It honours a global pipeline stall by holding the pending selection.

## Interface
- THREAD_INDEX_BITS, 3, thread index width; N = 2**THREAD_INDEX_BITS threads
- REISSUE_GAP, 5, minimum spacing between issues of one thread, in non-stall cycles; legal range 1..15
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_thread_enable  input  N  bit i set = thread i may run; sampled every cycle
- in_stall  input  1  pipeline stall; the current issue slot is not consumed
- in_block_valid  input  1  block the thread at in_block_thread_index
- in_block_thread_index  input  THREAD_INDEX_BITS  thread to block
- in_wake_valid  input  1  unblock the thread at in_wake_thread_index
- in_wake_thread_index  input  THREAD_INDEX_BITS  thread to wake
- out_thread_index  output  THREAD_INDEX_BITS  selected thread; drives PC array index
- out_issue_valid  output  1  issue this cycle; drives PC array increment flag
- out_idle  output  1  registered; no thread was eligible at the last selection

## Operation
- State:
  - issue_q (1 bit)
  - index_q
  - last pointer
  - blocked[N]
  - cooldown[N] (4 bits each, with macro only)
- eligible[i] = in_thread_enable[i] & ~blocked[i] & (cooldown[i]==0).
- Load condition: load = ~(issue_q & in_stall). On load:
  - Scan eligible from last+1, wrapping modulo N.
  - First hit: index_q<=hit, issue_q<=1, last<=hit, out_idle<=0.
  - No hit: issue_q<=0, index_q held, last held, out_idle<=1.
- When load=0 (stalled pending issue), index_q, issue_q, last and out_idle hold.
- out_issue_valid = issue_q & ~in_stall (combinational). out_thread_index = index_q.
- A held selection issues even if its thread is disabled or blocked while held. Enable and block affect only later selections.
- Block/wake:
  - Block sets blocked[idx]; wake clears it, effective the next edge.
  - Block and wake on the same index in the same cycle: block wins.
  - Block and wake on different indices: both apply.
  - Selection uses the registered blocked bits (a same-cycle block does not affect that cycle's scan).
- Cooldown (with macro):
  - On load with a hit, cooldown[hit]<=REISSUE_GAP-1.
  - Every other nonzero cooldown decrements on each edge where in_stall=0.
  - All cooldowns freeze while in_stall=1.
- Reset:
  - index_q=0, issue_q=0, out_issue_valid=0, out_idle=1.
  - last=N-1 (thread 0 is scanned first).
  - blocked all 0, cooldown all 0.
  - Reset overrides stall, block and wake.

## Timing
- Selection is combinational from registered state in cycle t and visible in cycle t+1. Latency is 1 cycle.
- First issue appears in the first cycle after reset deasserts, if thread 0 is enabled and the scan starts at thread 0.
- With the macro, one thread issues at most once every REISSUE_GAP non-stall cycles. REISSUE_GAP=1 allows back-to-back issue.
- Enable changes take effect on the next selection (1-cycle latency).
- Wake takes effect 2 cycles after in_wake_valid: register, then scan.
- Peak throughput is 1 issue per cycle when at least REISSUE_GAP threads are eligible.

## Configuration
- THREAD_SCHED_COOLDOWN_EN defined:
  - Cooldown counters are present; eligibility includes cooldown==0.
- Not defined:
  - No cooldown storage; eligible = enable & ~blocked.
  - REISSUE_GAP is ignored; a single enabled thread issues every non-stall cycle.

## Test plan
- Macro on, REISSUE_GAP=5, enable=8'hFF, no stall, reset released -> out_thread_index 0,1,2,...,7,0 on consecutive cycles; out_issue_valid constant 1.
- Macro on, REISSUE_GAP=5, enable=8'b0000_0101 -> indices 0,2 then 3 idle cycles, repeating; out_issue_valid pattern 1,1,0,0,0; out_idle=1 on the empty slots.
- enable=8'hFF, assert in_stall for 3 cycles while index_q=3, issue_q=1 -> out_issue_valid=0 and index held at 3 for 3 cycles; then 3 issues, followed by 4.
- Block thread 2 (enable=8'hFF, gap=1) -> 2 is skipped (…,1,3,…) until wake of 2; after the wake, 2 reappears within the next round. Same-cycle block+wake of thread 5 -> thread 5 stays blocked.
- Macro off, enable=8'b0000_1000 -> index 3 with out_issue_valid=1 every cycle.
- Assert reset mid-stream with index_q=6 and threads blocked -> next cycle out_issue_valid=0, out_idle=1, index 0, all blocked bits cleared; the first post-reset issue is thread 0.
